sm83_bus_responder: RTL and testbench

- Target side of the SM83 CPU memory bus. Decodes every CPU read or write and steers it to one of: external memory, the OAM port, internal HRAM, or the IE register.
- Contains the OAM DMA engine, triggered by a write to 0xFF46.
- Sits between the CPU datapath (the address/data bus driven by the control unit's addr_sel) and the cartridge/WRAM/IO fabric.

---
 rtl/sm83_bus_responder.sv | 217 +++++++++++++++++++++
 tb/tb_sm83_bus_responder.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_bus_responder.sv
// SM83 memory-bus target: decodes CPU accesses to ext, OAM, HRAM, IE and the FF46 register.
// Define SM83_BUS_RESPONDER_DMA_EN to build the OAM DMA engine; otherwise FF46 is a plain register.
module sm83_bus_responder #(
    parameter logic [15:0] HRAM_BASE = 16'hFF80,
    parameter int          DMA_LEN   = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] ext_addr,
    output logic        ext_rd,
    output logic        ext_wr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    output logic [7:0]  oam_addr,
    output logic        oam_we,
    output logic [7:0]  oam_wdata,
    input  logic [7:0]  oam_rdata,
    output logic        dma_active
);

    localparam int HRAM_SIZE = 65535 - int'(HRAM_BASE);
    localparam int HRAM_AW   = $clog2(HRAM_SIZE);

    typedef enum logic [1:0] {SRC_FF, SRC_EXT, SRC_OAM, SRC_INT} rd_src_t;

    logic               sel_ext, sel_oam, sel_hram, sel_ie, sel_ff46;
    logic               rd_req, bus_busy, cpu_ext, cpu_oam;
    logic [HRAM_AW-1:0] hram_idx;
    logic [7:0]         hram [HRAM_SIZE];
    logic [7:0]         ie_q, ff46_q, int_byte, rd_byte, rdata_q;
    rd_src_t            rd_src, rd_src_nx;
    logic               rd_pend;

    // A simultaneous read and write is treated as a write only.
    assign rd_req   = cpu_rd & ~cpu_wr;
    assign hram_idx = HRAM_AW'(cpu_addr - HRAM_BASE);

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        sel_ext  = 1'b0;
        sel_oam  = 1'b0;
        sel_hram = 1'b0;
        sel_ie   = 1'b0;
        sel_ff46 = 1'b0;
        if (cpu_addr < 16'hFE00) begin
            sel_ext = 1'b1;
        end else if (cpu_addr < 16'hFEA0) begin
            sel_oam = 1'b1;
        end else if (cpu_addr >= 16'hFF00) begin
            if (cpu_addr == 16'hFF46)
                sel_ff46 = 1'b1;
            else if (cpu_addr < HRAM_BASE)
                sel_ext = 1'b1;
            else if (cpu_addr == 16'hFFFF)
                sel_ie = 1'b1;
            else
                sel_hram = 1'b1;
        end
    end

    assign cpu_ext = ~rst & ~bus_busy & sel_ext & (rd_req | cpu_wr);
    assign cpu_oam = ~rst & ~bus_busy & sel_oam & (rd_req | cpu_wr);

    always_comb begin
        rd_src_nx = SRC_FF;
        int_byte  = 8'hFF;
        if (cpu_ext) begin
            rd_src_nx = SRC_EXT;
        end else if (cpu_oam) begin
            rd_src_nx = SRC_OAM;
        end else if (sel_hram) begin
            rd_src_nx = SRC_INT;
            int_byte  = hram[hram_idx];
        end else if (sel_ie) begin
            rd_src_nx = SRC_INT;
            int_byte  = ie_q;
        end else if (sel_ff46) begin
            rd_src_nx = SRC_INT;
            int_byte  = ff46_q;
        end
    end

    // NOTE: clocked state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            rd_src  <= SRC_FF;
            rd_byte <= 8'hFF;
            rdata_q <= 8'hFF;
            ie_q    <= 8'h00;
            ff46_q  <= 8'h00;
        end else begin
            rdata_q <= cpu_rdata;
            rd_pend <= rd_req;
            if (rd_req) begin
                rd_src  <= rd_src_nx;
                rd_byte <= int_byte;
            end
            if (cpu_wr && sel_ie)
                ie_q <= cpu_wdata;
            if (cpu_wr && sel_ff46)
                ff46_q <= cpu_wdata;
        end
    end

    // NOTE: HRAM has no reset; its contents are undefined after rst and a reset would prevent RAM mapping.
    always_ff @(posedge clk) begin
        if (cpu_wr && sel_hram)
            hram[hram_idx] <= cpu_wdata;
    end

    // Read data appears the cycle after the strobe, then holds until the next read completes.
    always_comb begin
        cpu_rdata = rdata_q;
        if (rd_pend) begin
            case (rd_src)
                SRC_EXT: cpu_rdata = ext_rdata;
                SRC_OAM: cpu_rdata = oam_rdata;
                SRC_INT: cpu_rdata = rd_byte;
                default: cpu_rdata = 8'hFF;
            endcase
        end
    end

`ifdef SM83_BUS_RESPONDER_DMA_EN
    localparam logic [7:0] DMA_LAST = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} dma_state_t;

    dma_state_t state, state_nx;
    logic [7:0] dma_idx, dma_idx_nx, wr_idx;
    logic       wr_pend, wr_pend_nx, dma_start;

    assign dma_start = cpu_wr & sel_ff46;

    // wr_pend marks the OAM write for the byte read in the previous RUN cycle; a restart drops it.
    always_comb begin
        state_nx   = state;
        dma_idx_nx = dma_idx;
        wr_pend_nx = 1'b0;
        case (state)
            ST_RUN: begin
                wr_pend_nx = 1'b1;
                if (dma_idx == DMA_LAST)
                    state_nx = ST_DRAIN;
                else
                    dma_idx_nx = dma_idx + 8'd1;
            end
            ST_DRAIN: state_nx = ST_IDLE;
            default:  state_nx = state;
        endcase
        if (dma_start) begin
            state_nx   = ST_RUN;
            dma_idx_nx = 8'd0;
            wr_pend_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            dma_idx <= 8'd0;
            wr_pend <= 1'b0;
            wr_idx  <= 8'd0;
        end else begin
            state   <= state_nx;
            dma_idx <= dma_idx_nx;
            wr_pend <= wr_pend_nx;
            wr_idx  <= dma_idx;
        end
    end

    assign bus_busy   = (state != ST_IDLE);
    assign dma_active = bus_busy;
`else
    assign bus_busy   = 1'b0;
    assign dma_active = 1'b0;
`endif

    always_comb begin
        ext_addr  = 16'h0000;
        ext_rd    = 1'b0;
        ext_wr    = 1'b0;
        ext_wdata = 8'h00;
        oam_addr  = 8'h00;
        oam_we    = 1'b0;
        oam_wdata = 8'h00;
        if (cpu_ext) begin
            ext_addr  = cpu_addr;
            ext_rd    = rd_req;
            ext_wr    = cpu_wr;
            ext_wdata = cpu_wr ? cpu_wdata : 8'h00;
        end
        if (cpu_oam) begin
            oam_addr  = cpu_addr[7:0];
            oam_we    = cpu_wr;
            oam_wdata = cpu_wr ? cpu_wdata : 8'h00;
        end
`ifdef SM83_BUS_RESPONDER_DMA_EN
        if (state == ST_RUN) begin
            ext_rd   = 1'b1;
            ext_addr = {ff46_q, dma_idx};
        end
        if (wr_pend) begin
            oam_we    = 1'b1;
            oam_addr  = wr_idx;
            oam_wdata = ext_rdata;
        end
`endif
    end

endmodule

// File: tb/tb_sm83_bus_responder.sv
// Bench for sm83_bus_responder: randomized bus traffic against a cycle-count reference model,
// plus directed literal checks for HRAM, IE, ext reads, DMA timing, restart and mid-DMA reset.
module tb_sm83_bus_responder;

`ifdef SM83_BUS_RESPONDER_DMA_EN
    localparam bit DMA_EN = 1'b1;
`else
    localparam bit DMA_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr;
    logic        cpu_rd, cpu_wr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic [15:0] ext_addr;
    logic        ext_rd, ext_wr;
    logic [7:0]  ext_wdata, ext_rdata;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_wdata, oam_rdata;
    logic        dma_active;

    sm83_bus_responder dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .ext_addr(ext_addr), .ext_rd(ext_rd), .ext_wr(ext_wr),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata),
        .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata),
        .oam_rdata(oam_rdata), .dma_active(dma_active)
    );

    initial forever #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {R_EXT, R_OAM, R_UNM, R_DMA, R_HRAM, R_IE} region_t;
    typedef enum {P_NONE, P_EXT, P_OAM, P_VAL} pend_t;

    int         cyc = 0;
    bit         dma_on = 1'b0;
    int         dma_start = 0;
    logic [7:0] dma_src = 8'h00;
    logic [7:0] m_hram [0:126];
    bit         m_hram_ok [0:126];
    logic [7:0] m_ie = 8'h00, m_ff46 = 8'h00;
    logic [7:0] hold = 8'hFF;
    bit         hold_ok = 1'b1;
    pend_t      pend = P_NONE;
    logic [7:0] pend_val = 8'hFF;
    bit         pend_ok = 1'b1;

    function automatic region_t region_of(input logic [15:0] a);
        if (a <= 16'hFDFF) return R_EXT;
        if (a <= 16'hFE9F) return R_OAM;
        if (a <= 16'hFEFF) return R_UNM;
        if (a == 16'hFF46) return R_DMA;
        if (a <= 16'hFF7F) return R_EXT;
        if (a == 16'hFFFF) return R_IE;
        return R_HRAM;
    endfunction

    task automatic model_cycle();
        region_t    rg;
        int         k, hi;
        bit         active, rd_eff, chk_oam_addr;
        logic       e_ext_rd, e_ext_wr, e_oam_we;
        logic [15:0] e_ext_addr;
        logic [7:0] e_ext_wdata, e_oam_addr, e_oam_wdata;
        cyc++;
        if (rst) begin
            check("rst cpu_rdata", 32'(cpu_rdata), 32'h FF);
            check("rst ext_rd", 32'(ext_rd), 32'd0);
            check("rst ext_wr", 32'(ext_wr), 32'd0);
            check("rst oam_we", 32'(oam_we), 32'd0);
            check("rst ext_addr", 32'(ext_addr), 32'd0);
            check("rst oam_addr", 32'(oam_addr), 32'd0);
            check("rst dma_active", 32'(dma_active), 32'd0);
            dma_on  = 1'b0;
            m_ie    = 8'h00;
            m_ff46  = 8'h00;
            hold    = 8'hFF;
            hold_ok = 1'b1;
            pend    = P_NONE;
            foreach (m_hram_ok[i]) m_hram_ok[i] = 1'b0;
            return;
        end

        // A DMA written in cycle S is active for S+1..S+161: reads at k=1..160, OAM writes at k=2..161.
        k = cyc - dma_start;
        if (dma_on && k > 161) dma_on = 1'b0;
        active = dma_on;
        rd_eff = cpu_rd && !cpu_wr;
        rg     = region_of(cpu_addr);

        e_ext_rd = 1'b0; e_ext_wr = 1'b0; e_ext_addr = 16'h0; e_ext_wdata = 8'h0;
        e_oam_we = 1'b0; e_oam_addr = 8'h0; e_oam_wdata = 8'h0; chk_oam_addr = 1'b0;
        if (active) begin
            if (k <= 160) begin
                e_ext_rd   = 1'b1;
                e_ext_addr = {dma_src, 8'(k - 1)};
            end
            if (k >= 2) begin
                e_oam_we     = 1'b1;
                e_oam_addr   = 8'(k - 2);
                e_oam_wdata  = ext_rdata;
                chk_oam_addr = 1'b1;
            end
        end else begin
            if (rg == R_EXT && (rd_eff || cpu_wr)) begin
                e_ext_rd    = rd_eff;
                e_ext_wr    = cpu_wr;
                e_ext_addr  = cpu_addr;
                e_ext_wdata = cpu_wdata;
            end
            if (rg == R_OAM && (rd_eff || cpu_wr)) begin
                e_oam_we     = cpu_wr;
                e_oam_addr   = 8'(cpu_addr - 16'hFE00);
                e_oam_wdata  = cpu_wdata;
                chk_oam_addr = 1'b1;
            end
        end

        check("dma_active", 32'(dma_active), 32'(active));
        check("ext_rd", 32'(ext_rd), 32'(e_ext_rd));
        check("ext_wr", 32'(ext_wr), 32'(e_ext_wr));
        if (e_ext_rd || e_ext_wr) check("ext_addr", 32'(ext_addr), 32'(e_ext_addr));
        if (e_ext_wr) check("ext_wdata", 32'(ext_wdata), 32'(e_ext_wdata));
        check("oam_we", 32'(oam_we), 32'(e_oam_we));
        if (chk_oam_addr) check("oam_addr", 32'(oam_addr), 32'(e_oam_addr));
        if (e_oam_we) check("oam_wdata", 32'(oam_wdata), 32'(e_oam_wdata));

        case (pend)
            P_EXT: begin hold = ext_rdata; hold_ok = 1'b1; end
            P_OAM: begin hold = oam_rdata; hold_ok = 1'b1; end
            P_VAL: begin hold = pend_val;  hold_ok = pend_ok; end
            default: ;
        endcase
        if (hold_ok) check("cpu_rdata", 32'(cpu_rdata), 32'(hold));

        pend = P_NONE;
        if (rd_eff) begin
            pend    = P_VAL;
            pend_ok = 1'b1;
            case (rg)
                R_EXT:  if (active) pend_val = 8'hFF; else pend = P_EXT;
                R_OAM:  if (active) pend_val = 8'hFF; else pend = P_OAM;
                R_UNM:  pend_val = 8'hFF;
                R_DMA:  pend_val = m_ff46;
                R_IE:   pend_val = m_ie;
                default: begin
                    hi       = int'(cpu_addr) - 'hFF80;
                    pend_val = m_hram[hi];
                    pend_ok  = m_hram_ok[hi];
                end
            endcase
        end

        if (cpu_wr) begin
            case (rg)
                R_HRAM: begin
                    hi            = int'(cpu_addr) - 'hFF80;
                    m_hram[hi]    = cpu_wdata;
                    m_hram_ok[hi] = 1'b1;
                end
                R_IE:  m_ie = cpu_wdata;
                R_DMA: begin
                    m_ff46 = cpu_wdata;
                    if (DMA_EN) begin
                        dma_on    = 1'b1;
                        dma_start = cyc;
                        dma_src   = cpu_wdata;
                    end
                end
                default: ;
            endcase
        end
    endtask

    initial begin : compare
        foreach (m_hram_ok[i]) m_hram_ok[i] = 1'b0;
        forever begin
            @(negedge clk);
            model_cycle();
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        cpu_rd    = rd;
        cpu_wr    = wr;
        cpu_addr  = a;
        cpu_wdata = d;
        ext_rdata = 8'($urandom);
        oam_rdata = 8'($urandom);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'($urandom), 8'($urandom));
    endtask

    task automatic rand_op();
        int          kind, m;
        logic [15:0] a;
        kind = $urandom_range(0, 6);
        m    = $urandom_range(0, 3);
        case (kind)
            0: a = 16'($urandom_range(0, 'hFDFF));
            1: a = 16'hFE00 + 16'($urandom_range(0, 159));
            2: a = 16'hFEA0 + 16'($urandom_range(0, 95));
            3: a = 16'hFF00 + 16'($urandom_range(0, 127));
            4: a = 16'hFF80 + 16'($urandom_range(0, 126));
            5: a = 16'hFFFF;
            default: a = ($urandom_range(0, 30) == 0) ? 16'hFF46 : 16'hFF80;
        endcase
        drive(m[0], m[1], a, 8'($urandom));
    endtask

    task automatic dma_basic();
        drive(1'b0, 1'b1, 16'hFF46, 8'hC1);
        for (int k = 1; k <= 162; k++) begin
            case (k)
                10: drive(1'b1, 1'b0, 16'hD000, 8'h00);
                20: drive(1'b0, 1'b1, 16'hFE10, 8'h99);
                30: drive(1'b0, 1'b1, 16'hFF90, 8'h77);
                31: drive(1'b1, 1'b0, 16'hFF90, 8'h00);
                40: drive(1'b1, 1'b0, 16'hFF46, 8'h00);
                default: idle();
            endcase
            @(negedge clk);
            if (k == 1)   check("dma first ext_addr", 32'(ext_addr), 32'h C100);
            if (k == 2)   check("dma first oam_addr", 32'(oam_addr), 32'd0);
            if (k == 11)  check("dma ext read blocked", 32'(cpu_rdata), 32'h FF);
            if (k == 20)  check("dma owns oam_addr", 32'(oam_addr), 32'd18);
            if (k == 32)  check("dma hram read", 32'(cpu_rdata), 32'h 77);
            if (k == 41)  check("dma ff46 read", 32'(cpu_rdata), 32'h C1);
            if (k == 160) check("dma last ext_addr", 32'(ext_addr), 32'h C19F);
            if (k == 161) check("dma last oam_addr", 32'(oam_addr), 32'd159);
            if (k == 161) check("dma active at N+161", 32'(dma_active), 32'd1);
            if (k == 162) check("dma done at N+162", 32'(dma_active), 32'd0);
        end
    endtask

    task automatic dma_restart();
        drive(1'b0, 1'b1, 16'hFF46, 8'hC1);
        for (int k = 1; k <= 51; k++) begin
            if (k == 51) drive(1'b0, 1'b1, 16'hFF46, 8'hD0);
            else idle();
        end
        @(negedge clk);
        check("restart at index 50", 32'(ext_addr), 32'h C132);
        for (int j = 1; j <= 162; j++) begin
            idle();
            @(negedge clk);
            if (j == 1)   check("restart ext_addr", 32'(ext_addr), 32'h D000);
            if (j == 1)   check("restart drops pending oam_we", 32'(oam_we), 32'd0);
            if (j == 2)   check("restart oam_addr", 32'(oam_addr), 32'd0);
            if (j == 161) check("restart active M+161", 32'(dma_active), 32'd1);
            if (j == 162) check("restart done M+162", 32'(dma_active), 32'd0);
        end
    endtask

    task automatic dma_reset();
        drive(1'b0, 1'b1, 16'hFFFF, 8'h1F);
        drive(1'b0, 1'b1, 16'hFF46, 8'hE0);
        repeat (81) idle();
        #1 rst = 1'b1;
        @(negedge clk);
        check("abort dma_active", 32'(dma_active), 32'd0);
        check("abort oam_we", 32'(oam_we), 32'd0);
        check("abort cpu_rdata", 32'(cpu_rdata), 32'h FF);
        idle();
        idle();
        rst = 1'b0;
        repeat (3) begin
            idle();
            @(negedge clk);
            check("idle after reset", 32'({dma_active, ext_rd, oam_we}), 32'd0);
        end
        drive(1'b1, 1'b0, 16'hFFFF, 8'h00);
        idle();
        @(negedge clk);
        check("IE cleared by reset", 32'(cpu_rdata), 32'h00);
    endtask

    initial begin : stimulus
        rst       = 1'b1;
        cpu_rd    = 1'b0;
        cpu_wr    = 1'b0;
        cpu_addr  = 16'h0000;
        cpu_wdata = 8'h00;
        ext_rdata = 8'h00;
        oam_rdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        drive(1'b0, 1'b1, 16'hFF80, 8'h5A);
        drive(1'b1, 1'b0, 16'hFF80, 8'h00);
        idle();
        @(negedge clk);
        check("hram FF80", 32'(cpu_rdata), 32'h 5A);

        drive(1'b0, 1'b1, 16'hFFFF, 8'h1F);
        drive(1'b1, 1'b0, 16'hFFFF, 8'h00);
        idle();
        @(negedge clk);
        check("IE FFFF", 32'(cpu_rdata), 32'h 1F);

        drive(1'b1, 1'b0, 16'hC000, 8'h00);
        @(negedge clk);
        check("ext_rd C000", 32'(ext_rd), 32'd1);
        check("ext_addr C000", 32'(ext_addr), 32'h C000);
        idle();
        ext_rdata = 8'h33;
        @(negedge clk);
        check("ext read data", 32'(cpu_rdata), 32'h 33);

        drive(1'b1, 1'b1, 16'hFF81, 8'hA7);
        idle();
        @(negedge clk);
        check("rd+wr holds rdata", 32'(cpu_rdata), 32'h 33);
        drive(1'b1, 1'b0, 16'hFF81, 8'h00);
        idle();
        @(negedge clk);
        check("rd+wr wrote hram", 32'(cpu_rdata), 32'h A7);

        repeat (1500) rand_op();
        repeat (170) idle();

`ifdef SM83_BUS_RESPONDER_DMA_EN
        dma_basic();
        dma_restart();
        dma_reset();
`else
        drive(1'b0, 1'b1, 16'hFF46, 8'hC1);
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        idle();
        @(negedge clk);
        check("ff46 plain register", 32'(cpu_rdata), 32'h C1);
        check("no dma without feature", 32'({dma_active, ext_rd}), 32'd0);
`endif

        repeat (1500) rand_op();
        repeat (4) idle();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
